// File: rtl/regfile_wr_demux_if.sv
// Write/read bundle of the register file: writeback request, pipeline controls,
// two combinational read ports and the commit observation signals.
interface regfile_wr_demux_if #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
);
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              stall;
  logic              flush;
  logic [4:0]        rd_addr0;
  logic [4:0]        rd_addr1;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;
  logic [NREG-1:0]   wr_sel;
  logic              pend_valid;

  modport master (
    output wr_en, wr_addr, wr_data, stall, flush, rd_addr0, rd_addr1,
    input  rd_data0, rd_data1, wr_sel, pend_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, stall, flush, rd_addr0, rd_addr1,
    output rd_data0, rd_data1, wr_sel, pend_valid
  );
endinterface

// File: rtl/regfile_wr_demux.sv
// Register file with one write staging entry: a write commits one edge after capture, reads bypass the staged entry.
// stall freezes the staging entry without committing; flush drops it (flush beats stall); register 31 reads zero.
module regfile_wr_demux #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input logic               clk,
  input logic               reset,
  regfile_wr_demux_if.slave bus
);
  localparam logic [4:0] ZR = 5'd31;

  logic [DATA_W-1:0] regs [NREG];
  logic              pend_valid;
  logic [4:0]        pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [NREG-1:0]   commit_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      commit_sel <= '0;
    end else begin
      commit_sel <= '0;
      if (bus.flush) begin
        pend_valid <= 1'b0;
      end else if (!bus.stall) begin
        // The guard on ZR is defensive: a staged entry never carries address 31.
        if (pend_valid && pend_addr != ZR) begin
          regs[pend_addr] <= pend_data;
          commit_sel      <= {{(NREG-1){1'b0}}, 1'b1} << pend_addr;
        end
        pend_valid <= bus.wr_en && (bus.wr_addr != ZR);
        pend_addr  <= bus.wr_addr;
        pend_data  <= bus.wr_data;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd_mux(input logic [4:0] a);
    if (a == ZR)                      return '0;
    if (pend_valid && pend_addr == a) return pend_data;
    return regs[a];
  endfunction

  assign bus.rd_data0   = rd_mux(bus.rd_addr0);
  assign bus.rd_data1   = rd_mux(bus.rd_addr1);
  assign bus.wr_sel     = commit_sel;
  assign bus.pend_valid = pend_valid;

  a_sel_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(commit_sel));
endmodule

// File: tb/tb_regfile_wr_demux.sv
// Directed scenarios plus randomized traffic checked against a queue-based write model.
module tb_regfile_wr_demux;
  localparam int DW = 64;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wr_demux_if #(.DATA_W(DW), .NREG(NR)) bus ();
  regfile_wr_demux #(.DATA_W(DW), .NREG(NR)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           pend_q[$];
  logic [DW-1:0] mem [NR];
  logic [NR-1:0] sel_m;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mref(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (pend_q.size() != 0 && pend_q[0].addr == a) return pend_q[0].data;
    return mem[a];
  endfunction

  // Reference behaviour at a rising edge, from the inputs present at that edge.
  task automatic model_edge();
    wr_t w;
    if (!reset) return;
    sel_m = '0;
    if (bus.flush) begin
      pend_q.delete();
    end else if (!bus.stall) begin
      if (pend_q.size() != 0) begin
        w = pend_q.pop_front();
        mem[w.addr] = w.data;
        sel_m[w.addr] = 1'b1;
      end
      if (bus.wr_en && bus.wr_addr != 5'd31) begin
        w.addr = bus.wr_addr;
        w.data = bus.wr_data;
        pend_q.push_back(w);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic en, input logic [4:0] a, input logic [DW-1:0] d,
                       input logic st, input logic fl);
    bus.wr_en = en; bus.wr_addr = a; bus.wr_data = d; bus.stall = st; bus.flush = fl;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pend_valid"}, DW'(bus.pend_valid), DW'(pend_q.size() != 0));
    check({tag, ".wr_sel"}, DW'(bus.wr_sel), DW'(sel_m));
    check({tag, ".rd0"}, bus.rd_data0, mref(bus.rd_addr0));
    check({tag, ".rd1"}, bus.rd_data1, mref(bus.rd_addr1));
  endtask

  task automatic model_clear();
    pend_q.delete();
    sel_m = '0;
    for (int i = 0; i < NR; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    model_clear();
    #1;
    check("rst.pend_valid", DW'(bus.pend_valid), '0);
    check("rst.wr_sel", DW'(bus.wr_sel), '0);
    for (int i = 0; i < NR; i++) begin
      bus.rd_addr0 = 5'(i);
      bus.rd_addr1 = 5'(NR - 1 - i);
      #1;
      check("rst.rd0", bus.rd_data0, '0);
      check("rst.rd1", bus.rd_data1, '0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
    bus.rd_addr0 = 5'd0;
    bus.rd_addr1 = 5'd0;
    model_clear();
    #2;
    do_reset();

    // Single write: bypass after one edge, storage plus commit strobe after two.
    drive(1'b1, 5'd5, 64'hA5A5, 1'b0, 1'b0);
    bus.rd_addr0 = 5'd5;
    cyc();
    check("w5.pv", DW'(bus.pend_valid), 64'd1);
    check("w5.bypass", bus.rd_data0, 64'hA5A5);
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
    cyc();
    check("w5.sel", DW'(bus.wr_sel), 64'h20);
    check("w5.pv0", DW'(bus.pend_valid), 64'd0);
    check("w5.store", bus.rd_data0, 64'hA5A5);
    cyc();
    check("w5.sel_idle", DW'(bus.wr_sel), 64'd0);

    // Back-to-back writes to the same address, newest value wins.
    bus.rd_addr1 = 5'd3;
    drive(1'b1, 5'd3, 64'h11, 1'b0, 1'b0); cyc(); check("b2b.rd1a", bus.rd_data1, 64'h11);
    drive(1'b1, 5'd3, 64'h22, 1'b0, 1'b0); cyc(); check("b2b.rd1b", bus.rd_data1, 64'h22);
    check("b2b.sel1", DW'(bus.wr_sel), 64'h8);
    drive(1'b1, 5'd3, 64'h33, 1'b0, 1'b0); cyc(); check("b2b.rd1c", bus.rd_data1, 64'h33);
    check("b2b.sel2", DW'(bus.wr_sel), 64'h8);
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0);     cyc(); check("b2b.rd1d", bus.rd_data1, 64'h33);
    check("b2b.sel3", DW'(bus.wr_sel), 64'h8);
    cyc();
    check("b2b.rd1e", bus.rd_data1, 64'h33);
    check("b2b.sel4", DW'(bus.wr_sel), 64'h0);

    // Writes to XZR vanish.
    bus.rd_addr0 = 5'd31;
    drive(1'b1, 5'd31, 64'hFFFF, 1'b0, 1'b0); cyc();
    check("xzr.pv", DW'(bus.pend_valid), 64'd0);
    check("xzr.rd0", bus.rd_data0, 64'd0);
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0); cyc();
    check("xzr.sel", DW'(bus.wr_sel), 64'd0);

    // Stall holds the staged write and ignores new requests.
    do_reset();
    bus.rd_addr0 = 5'd7;
    bus.rd_addr1 = 5'd8;
    drive(1'b1, 5'd7, 64'h77, 1'b0, 1'b0); cyc();
    drive(1'b1, 5'd8, 64'h88, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall.sel", DW'(bus.wr_sel), 64'd0);
      check("stall.pv", DW'(bus.pend_valid), 64'd1);
      check("stall.rd7", bus.rd_data0, 64'h77);
      check("stall.rd8", bus.rd_data1, 64'd0);
    end
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0); cyc();
    check("stall.sel7", DW'(bus.wr_sel), 64'h80);
    check("stall.reg7", bus.rd_data0, 64'h77);
    check_all("stall.end");

    // Flush beats stall and drops the staged write.
    do_reset();
    bus.rd_addr0 = 5'd9;
    bus.rd_addr1 = 5'd10;
    drive(1'b1, 5'd9, 64'h99, 1'b0, 1'b0); cyc();
    drive(1'b1, 5'd10, 64'hAA, 1'b1, 1'b1); cyc();
    check("flush.pv", DW'(bus.pend_valid), 64'd0);
    check("flush.sel", DW'(bus.wr_sel), 64'd0);
    check("flush.rd9", bus.rd_data0, 64'd0);
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0); cyc();
    check("flush.sel2", DW'(bus.wr_sel), 64'd0);
    check("flush.rd9b", bus.rd_data0, 64'd0);
    check("flush.rd10", bus.rd_data1, 64'd0);

    // Asynchronous reset with a write staged.
    bus.rd_addr0 = 5'd4;
    drive(1'b1, 5'd4, 64'h44, 1'b0, 1'b0); cyc();
    check("arst.pv_before", DW'(bus.pend_valid), 64'd1);
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    model_clear();
    #1;
    check("arst.pv", DW'(bus.pend_valid), 64'd0);
    check("arst.sel", DW'(bus.wr_sel), 64'd0);
    check("arst.rd4", bus.rd_data0, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    check("arst.sel_post", DW'(bus.wr_sel), 64'd0);
    check("arst.rd4_post", bus.rd_data0, 64'd0);

    // Randomized traffic; a narrow address range forces collisions.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) a = 5'd31;
      drive(1'($urandom_range(0, 9) < 7), a, {$urandom, $urandom},
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
      bus.rd_addr0 = ($urandom_range(0, 1) == 0) ? a : 5'($urandom_range(0, 31));
      bus.rd_addr1 = ($urandom_range(0, 3) == 0) ? bus.rd_addr0 : 5'($urandom_range(0, 7));
      cyc();
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
